// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the multi-port byte-serial memory arbiter.
// Size encodings, FSM state enum and the read-data extension helper live here.
package mem_port_arbiter_pkg;

    localparam logic [1:0] SIZE_B     = 2'b00;
    localparam logic [1:0] SIZE_H     = 2'b01;
    localparam logic [1:0] SIZE_W     = 2'b10;
    localparam logic [1:0] IO_BASE_HI = 2'b11;
    localparam int         BYTE_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } arb_state_e;

    // Size code 11 is treated as a word.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            SIZE_W:  return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend_rdata(input logic [31:0] raw,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        case (size)
            SIZE_B:  return {{24{sgn & raw[7]}}, raw[7:0]};
            SIZE_H:  return {{16{sgn & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and external memory bus bundle. master = requesters plus memory
// model side, slave = the arbiter itself.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32
);
    // Handshake: a port raises req_valid with stable fields and holds them until
    // its done_o pulse; grant_o marks the port that owns the memory bus meanwhile.
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS-1:0]        req_we;
    logic [2*NUM_PORTS-1:0]      req_size;
    logic [NUM_PORTS-1:0]        req_signed;
    logic [ADDR_W*NUM_PORTS-1:0] req_addr;
    logic [32*NUM_PORTS-1:0]     req_wdata;
    logic [NUM_PORTS-1:0]        grant_o;
    logic [NUM_PORTS-1:0]        done_o;
    logic [31:0]                 rdata_o;
    logic                        busy_o;
    logic [7:0]                  mem_din;
    logic [7:0]                  mem_dout;
    logic [ADDR_W-1:0]           mem_a;
    logic                        mem_wr;
    arb_state_e                  state_dbg;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_din,
        input  grant_o, done_o, rdata_o, busy_o, mem_dout, mem_a, mem_wr, state_dbg
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_din,
        output grant_o, done_o, rdata_o, busy_o, mem_dout, mem_a, mem_wr, state_dbg
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin picker: one-hot grant to the first valid port at or after ptr.
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = 1
) (
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [PTR_W-1:0]     ptr,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_PORTS);
            if (en && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that serialises 1/2/4-byte requests onto an 8-bit memory
// bus, little-endian, with reads pipelined across the memory's read latency.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int IO_SERIAL = 1
) (
    input logic               clk_in,
    input logic               rst_in,
    input logic               rdy_in,
    mem_port_arbiter_if.slave bus
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    arb_state_e           state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 done_q, done_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [2:0]           len_q, len_d;
    logic [1:0]           size_q, size_d;
    logic                 signed_q, signed_d;
    logic                 io_q, io_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          rbuf_q, rbuf_d;
    logic [2:0]           iss_q, iss_d;
    logic [2:0]           cap_q, cap_d;
    logic                 a_live_q, a_live_d;
    logic                 d_live_q, d_live_d;
    logic                 prev_rdy_q, prev_rdy_d;
    logic [ADDR_W-1:0]    mem_a_q, mem_a_d;
    logic [7:0]           mem_dout_q, mem_dout_d;
    logic                 mem_wr_q, mem_wr_d;

    logic [NUM_PORTS-1:0] arb_gnt;
    logic                 sel_we, sel_signed;
    logic [1:0]           sel_size;
    logic [ADDR_W-1:0]    sel_addr;
    logic [31:0]          sel_wdata;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_rr (
        .valid (bus.req_valid),
        .ptr   (ptr_q),
        .en    ((state_q == ST_IDLE) && rdy_in),
        .grant (arb_gnt)
    );

    always_comb begin
        sel_we     = 1'b0;
        sel_signed = 1'b0;
        sel_size   = '0;
        sel_addr   = '0;
        sel_wdata  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (arb_gnt[p]) begin
                sel_we     = bus.req_we[p];
                sel_signed = bus.req_signed[p];
                sel_size   = bus.req_size[2*p +: 2];
                sel_addr   = bus.req_addr[p*ADDR_W +: ADDR_W];
                sel_wdata  = bus.req_wdata[32*p +: 32];
            end
        end
    end

    // a_live: mem_a this cycle is a read issue; d_live: mem_din this cycle holds
    // byte cap_q. After a stall the pipeline is flushed and re-issued from cap_q.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        done_d     = done_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        signed_d   = signed_q;
        io_d       = io_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        iss_d      = iss_q;
        cap_d      = cap_q;
        a_live_d   = a_live_q;
        d_live_d   = d_live_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        prev_rdy_d = rdy_in;
        if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    if (|arb_gnt) begin
                        grant_d    = arb_gnt;
                        ptr_d      = PTR_W'((int'(onehot_idx(8'(arb_gnt))) + 1) % NUM_PORTS);
                        addr_d     = sel_addr;
                        len_d      = size_to_len(sel_size);
                        size_d     = sel_size;
                        signed_d   = sel_signed;
                        io_d       = (IO_SERIAL != 0) && (sel_addr[17:16] == IO_BASE_HI);
                        wdata_d    = sel_wdata;
                        rbuf_d     = '0;
                        iss_d      = 3'd1;
                        cap_d      = 3'd0;
                        d_live_d   = 1'b0;
                        mem_a_d    = sel_addr;
                        mem_dout_d = sel_wdata[BYTE_W-1:0];
                        mem_wr_d   = sel_we;
                        a_live_d   = !sel_we;
                        state_d    = sel_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_WRITE: begin
                    if (iss_q == len_q) begin
                        state_d  = ST_DONE;
                        mem_wr_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        mem_a_d    = addr_q + ADDR_W'(iss_q);
                        mem_dout_d = BYTE_W'(wdata_q >> (BYTE_W * int'(iss_q)));
                        iss_d      = iss_q + 3'd1;
                    end
                end
                ST_READ: begin
                    if (!prev_rdy_q) begin
                        mem_a_d  = addr_q + ADDR_W'(cap_q);
                        a_live_d = 1'b1;
                        d_live_d = 1'b0;
                        iss_d    = cap_q + 3'd1;
                    end else begin
                        d_live_d = a_live_q;
                        a_live_d = 1'b0;
                        if (d_live_q) begin
                            rbuf_d = rbuf_q | (32'(bus.mem_din) << (BYTE_W * int'(cap_q)));
                            cap_d  = cap_q + 3'd1;
                        end
                        if (cap_d == len_q) begin
                            state_d  = ST_DONE;
                            done_d   = 1'b1;
                            rdata_d  = extend_rdata(rbuf_d, size_q, signed_q);
                            d_live_d = 1'b0;
                        end else if ((iss_q < len_q) && (!io_q || (cap_d == iss_q))) begin
                            mem_a_d  = addr_q + ADDR_W'(iss_q);
                            a_live_d = 1'b1;
                            iss_d    = iss_q + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                    grant_d = '0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            io_q       <= 1'b0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            iss_q      <= '0;
            cap_q      <= '0;
            a_live_q   <= 1'b0;
            d_live_q   <= 1'b0;
            prev_rdy_q <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            io_q       <= io_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            a_live_q   <= a_live_d;
            d_live_q   <= d_live_d;
            prev_rdy_q <= prev_rdy_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    // A paused bus must never see a write strobe or a completion pulse.
    assign bus.mem_wr    = mem_wr_q & rdy_in;
    assign bus.done_o    = grant_q & {NUM_PORTS{done_q & rdy_in}};
    assign bus.grant_o   = grant_q;
    assign bus.rdata_o   = rdata_q;
    assign bus.busy_o    = (state_q != ST_IDLE);
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_dout  = mem_dout_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: 2 ports, 32-bit addresses, IO_SERIAL=1,
// with a small ROM that answers one cycle after the address is registered.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] rd_q = 8'h00;
    logic [1:0] exp_q[$];

    mem_port_arbiter_if #(.NUM_PORTS(2), .ADDR_W(32)) bus ();

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .IO_SERIAL(1)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic logic [7:0] rom(input logic [9:0] a);
        case (a)
            10'h100: return 8'h11;
            10'h101: return 8'h22;
            10'h102: return 8'h33;
            10'h103: return 8'h44;
            10'h080: return 8'h80;
            10'h010: return 8'hAB;
            10'h011: return 8'hCD;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk_in) rd_q <= rom(bus.mem_a[9:0]);
    assign bus.mem_din = rd_q;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int p, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_we[p]             = we;
        bus.req_size[2*p +: 2]    = size;
        bus.req_signed[p]         = sgn;
        bus.req_addr[32*p +: 32]  = addr;
        bus.req_wdata[32*p +: 32] = wdata;
        bus.req_valid[p]          = 1'b1;
    endtask

    task automatic wait_done(input int port, input string tag);
        int n;
        n = 0;
        while (bus.done_o[port] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(bus.done_o[port]), 32'd1);
    endtask

    initial begin
        int n;
        int last_cyc;
        logic [1:0] exp_oh;

        bus.req_valid  = '0;
        bus.req_we     = '0;
        bus.req_size   = '0;
        bus.req_signed = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        // Reset state
        repeat (3) tick();
        check("rst_grant", 32'(bus.grant_o), 32'h0);
        check("rst_done", 32'(bus.done_o), 32'h0);
        check("rst_rdata", bus.rdata_o, 32'h0);
        check("rst_mem_a", bus.mem_a, 32'h0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
        check("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
        check("rst_busy", 32'(bus.busy_o), 32'h0);
        rst_in = 1'b0;
        tick();

        // Port 1 alone right after reset is granted immediately
        set_req(1, 1'b0, SIZE_B, 1'b0, 32'h80, 32'h0);
        tick();
        check("p1_grant", 32'(bus.grant_o), 32'h2);
        check("p1_mem_a", bus.mem_a, 32'h80);
        check("p1_busy", 32'(bus.busy_o), 32'h1);
        tick();
        check("p1_early_done", 32'(bus.done_o), 32'h0);
        tick();
        check("p1_done", 32'(bus.done_o), 32'h2);
        check("p1_rdata", bus.rdata_o, 32'h00000080);
        bus.req_valid = '0;
        tick();

        // Word read at 0x100: addresses G+1..G+4, done at G+6
        set_req(0, 1'b0, SIZE_W, 1'b0, 32'h100, 32'h0);
        tick();
        check("wr0_grant", 32'(bus.grant_o), 32'h1);
        check("wr0_a0", bus.mem_a, 32'h100);
        check("wr0_wr", 32'(bus.mem_wr), 32'h0);
        tick();
        check("wr0_a1", bus.mem_a, 32'h101);
        tick();
        check("wr0_a2", bus.mem_a, 32'h102);
        tick();
        check("wr0_a3", bus.mem_a, 32'h103);
        tick();
        check("wr0_early_done", 32'(bus.done_o), 32'h0);
        tick();
        check("wr0_done", 32'(bus.done_o), 32'h1);
        check("wr0_rdata", bus.rdata_o, 32'h44332211);
        bus.req_valid = '0;
        tick();
        check("wr0_idle_busy", 32'(bus.busy_o), 32'h0);
        check("wr0_idle_done", 32'(bus.done_o), 32'h0);
        check("wr0_rdata_hold", bus.rdata_o, 32'h44332211);

        // Signed byte read at 0x80, done at G+3
        set_req(0, 1'b0, SIZE_B, 1'b1, 32'h80, 32'h0);
        tick();
        tick();
        check("sb_early_done", 32'(bus.done_o), 32'h0);
        tick();
        check("sb_done", 32'(bus.done_o), 32'h1);
        check("sb_rdata", bus.rdata_o, 32'hFFFFFF80);
        bus.req_valid = '0;
        tick();

        // Word write of 0xDEADBEEF at 0x200
        set_req(0, 1'b1, SIZE_W, 1'b0, 32'h200, 32'hDEADBEEF);
        tick();
        check("ww_wr0", 32'(bus.mem_wr), 32'h1);
        check("ww_a0", bus.mem_a, 32'h200);
        check("ww_d0", 32'(bus.mem_dout), 32'hEF);
        tick();
        check("ww_a1", bus.mem_a, 32'h201);
        check("ww_d1", 32'(bus.mem_dout), 32'hBE);
        tick();
        check("ww_d2", 32'(bus.mem_dout), 32'hAD);
        tick();
        check("ww_a3", bus.mem_a, 32'h203);
        check("ww_d3", 32'(bus.mem_dout), 32'hDE);
        check("ww_wr3", 32'(bus.mem_wr), 32'h1);
        tick();
        check("ww_done", 32'(bus.done_o), 32'h1);
        check("ww_wr_off", 32'(bus.mem_wr), 32'h0);
        bus.req_valid = '0;
        tick();

        // I/O-space signed half read on port 1: serialised, done at G+2n+1
        set_req(1, 1'b0, SIZE_H, 1'b1, 32'h0003_0010, 32'h0);
        tick();
        check("io_grant", 32'(bus.grant_o), 32'h2);
        check("io_a0", bus.mem_a, 32'h0003_0010);
        tick();
        check("io_a0_hold", bus.mem_a, 32'h0003_0010);
        tick();
        check("io_a1", bus.mem_a, 32'h0003_0011);
        tick();
        check("io_early_done", 32'(bus.done_o), 32'h0);
        tick();
        check("io_done", 32'(bus.done_o), 32'h2);
        check("io_rdata", bus.rdata_o, 32'hFFFFCDAB);
        bus.req_valid = '0;
        tick();

        // Both ports requesting continuously: strict alternation, 4-cycle spacing
        exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
        set_req(0, 1'b0, SIZE_B, 1'b0, 32'h80, 32'h0);
        set_req(1, 1'b0, SIZE_B, 1'b0, 32'h100, 32'h0);
        last_cyc = 0;
        for (int t = 0; t < 4; t++) begin
            n = 0;
            while (bus.done_o === 2'b00 && n < 20) begin
                tick();
                n++;
            end
            exp_oh = exp_q.pop_front();
            check("rr_done_port", 32'(bus.done_o), 32'(exp_oh));
            check("rr_rdata", bus.rdata_o, (exp_oh == 2'b01) ? 32'h80 : 32'h11);
            if (t > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd4);
            last_cyc = cyc;
            tick();
        end
        bus.req_valid = '0;
        tick();

        // Word read with rdy_in low for 3 cycles after the second byte is issued
        set_req(0, 1'b0, SIZE_W, 1'b0, 32'h100, 32'h0);
        tick();
        tick();
        check("st_a1", bus.mem_a, 32'h101);
        rdy_in = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("st_no_wr", 32'(bus.mem_wr), 32'h0);
            check("st_no_done", 32'(bus.done_o), 32'h0);
        end
        rdy_in = 1'b1;
        wait_done(0, "st");
        check("st_rdata", bus.rdata_o, 32'h44332211);
        bus.req_valid = '0;
        tick();

        // Write stalled then reset mid-transfer; pointer returns to port 0
        set_req(0, 1'b1, SIZE_W, 1'b0, 32'h300, 32'h12345678);
        tick();
        rdy_in = 1'b0;
        #1;
        check("rw_wr_gated", 32'(bus.mem_wr), 32'h0);
        tick();
        rdy_in = 1'b1;
        #1;
        check("rw_hold_a", bus.mem_a, 32'h300);
        check("rw_hold_wr", 32'(bus.mem_wr), 32'h1);
        tick();
        check("rw_a1", bus.mem_a, 32'h301);
        rst_in = 1'b1;
        #1;
        check("rw_rst_wr", 32'(bus.mem_wr), 32'h0);
        check("rw_rst_grant", 32'(bus.grant_o), 32'h0);
        check("rw_rst_done", 32'(bus.done_o), 32'h0);
        check("rw_rst_busy", 32'(bus.busy_o), 32'h0);
        tick();
        set_req(0, 1'b0, SIZE_B, 1'b0, 32'h80, 32'h0);
        set_req(1, 1'b0, SIZE_B, 1'b0, 32'h100, 32'h0);
        rst_in = 1'b0;
        tick();
        check("rw_post_grant", 32'(bus.grant_o), 32'h1);
        wait_done(0, "rw_p0");
        check("rw_p0_rdata", bus.rdata_o, 32'h80);
        bus.req_valid[0] = 1'b0;
        wait_done(1, "rw_p1");
        check("rw_p1_rdata", bus.rdata_o, 32'h11);
        bus.req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Multi-channel memory interface between the pipeline's requesters (instruction fetch, load/store, later caches) and the 8-bit external memory bus. Arbitrates round-robin among NUM_PORTS requesters. Serialises each granted 1/2/4-byte access into little-endian byte transactions, pipelining reads across the 2-cycle memory read latency. Replaces the single fixed ROM fetch path and honours the rdy_in pause.

Parameters:
NUM_PORTS, 2, number of requester channels (1..8); port 0 wins the first arbitration after reset
ADDR_W, 32, address width of requests and of mem_a
IO_SERIAL, 1, when 1, accesses with addr[17:16]==2'b11 are not read-pipelined

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  memory ready; low freezes the block
req_valid  in  NUM_PORTS  per-port request; held high until that port's done
req_we  in  NUM_PORTS  1 = write, 0 = read
req_size  in  2*NUM_PORTS  00 byte, 01 half, 10 word (11 treated as word)
req_signed  in  NUM_PORTS  sign-extend byte/half reads
req_addr  in  ADDR_W*NUM_PORTS  byte address
req_wdata  in  32*NUM_PORTS  write data, low bytes used
grant_o  out  NUM_PORTS  one-hot, high for the whole active transaction
done_o  out  NUM_PORTS  one-cycle completion pulse for the granted port
rdata_o  out  32  read result, valid while done_o is high
busy_o  out  1  FSM not IDLE
mem_din  in  8  memory read data
mem_dout  out  8  memory write data
mem_a  out  ADDR_W  memory byte address
mem_wr  out  1  1 = write strobe

Behaviour:
- Reset (async): state IDLE, grant_o/done_o/rdata_o = 0, mem_a/mem_dout = 0, mem_wr = 0, rr pointer = 0. Any in-flight request is dropped, with no done pulse.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: if any req_valid, grant the first valid port at or after the rr pointer (cycle G).
  - Latch addr, size, we, signed and wdata; set the pointer to the granted port + 1 (mod NUM_PORTS).
  - Go to READ or WRITE. n = 1/2/4 bytes.
- WRITE: cycles G+1..G+n drive mem_wr=1, mem_a=addr+i, mem_dout=wdata byte i.
  - Cycle G+n+1 is DONE: done_o pulses and the FSM returns to IDLE.
- READ (pipelined):
  - Cycles G+1..G+n drive mem_a=addr+i, mem_wr=0.
  - Byte i is sampled from mem_din one cycle after its address (G+i+2 edge).
  - Cycle G+n+2 is DONE, with rdata_o assembled little-endian, sign- or zero-extended per req_signed and size.
- IO_SERIAL with an I/O address: read byte i+1 is issued only after byte i has been captured. A read completes at G+2n+1.
- Separate issue and capture counters (0..4) are used; the address adder wraps modulo 2^ADDR_W.
- DONE → IDLE. A new grant may occur in the cycle after DONE; arbitration never takes place in DONE.
- rdy_in low:
  - All state, counters, captured bytes and the pointer hold.
  - mem_wr is forced to 0 and done_o is held low. A DONE cycle is deferred until rdy_in returns.
  - A capture due in a stalled cycle is lost. On resume, issue restarts from the first uncaptured byte, so the result is identical to an unstalled access.
- rdata_o holds its last value outside DONE.
- Deasserting req_valid mid-transaction is illegal and is ignored.
- Simultaneous requests from all ports are served strictly round-robin. No port waits more than NUM_PORTS-1 transactions.

Decomposition:
- Shared package holds:
  - size encodings (SIZE_B/H/W)
  - FSM state enum
  - IO_BASE_HI = 2'b11
  - BYTE_W = 8
- Sub-module rr_arbiter (NUM_PORTS): inputs valid vector, pointer and enable; output one-hot grant.

Test Plan:
- Port0 word read at 0x100, memory bytes 11 22 33 44 → mem_a 0x100..0x103 on G+1..G+4; done_o[0] at G+6; rdata_o = 0x44332211.
- Byte read at 0x80 holding 0x80 → rdata_o = 0xFFFFFF80 with req_signed=1; 0x00000080 with req_signed=0. Done at G+3.
- Word write of 0xDEADBEEF at 0x200 → mem_dout EF, BE, AD, DE with mem_wr=1 on G+1..G+4; done at G+5.
- Ports 0 and 1 both requesting continuously → grant order 0,1,0,1 with one idle cycle between transactions; port1 alone after reset is granted immediately.
- rdy_in low for 3 cycles after the second byte of a word read → no mem_wr, no done_o during the stall; final rdata_o equals the unstalled value.
- rst_in asserted during WRITE at G+2 → mem_wr=0 and grant_o=0 immediately; no done_o; next grant goes to port 0.
